// File: rtl/posit_add_sched_es3.sv
// Round-robin scheduler sharing one fixed-latency es3 posit adder among NREQ
// requesters. Each issued add carries its requester id down a tag line matched
// to the adder latency; sums land in per-requester FIFOs guarded by credits.

// Per-requester result FIFO plus credit counter (in-flight + stored entries).
module posit_add_sched_es3_lane #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         grant,
  input  logic         wr_en,
  input  logic [W:0]   wr_data,
  input  logic         pop,
  output logic         has_credit,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         res_truncated
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] credit, occ;
  logic [PW-1:0] wp, rp;
  logic [W:0]    mem [DEPTH];
  logic          pop_ok;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign res_valid  = (occ != '0);
  assign pop_ok     = pop & res_valid;
  assign has_credit = (credit < CW'(DEPTH));
  assign {res_truncated, res_data} = mem[rp];

  // Credit: +1 on grant, -1 on pop, unchanged when both happen together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credit <= '0;
    else begin
      case ({grant, pop_ok})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy; credits make a full-FIFO write impossible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (wr_en)  wp <= inc_ptr(wp);
      if (pop_ok) rp <= inc_ptr(rp);
      case ({wr_en, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy qualifies the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end
endmodule

module posit_add_sched_es3 #(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = 8,
  parameter int RES_DEPTH   = 4,
  parameter int W_IN        = 38,  // POSIT_SERIALIZED_WIDTH_ES3
  parameter int W_SUM       = 40   // POSIT_SERIALIZED_WIDTH_SUM_ES3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*W_IN-1:0]  req_in1,
  input  logic [NREQ*W_IN-1:0]  req_in2,
  output logic                  add_start,
  output logic [W_IN-1:0]       add_in1,
  output logic [W_IN-1:0]       add_in2,
  input  logic [W_SUM-1:0]      add_result,
  input  logic                  add_done,
  input  logic                  add_truncated,
  output logic [NREQ-1:0]       res_valid,
  input  logic [NREQ-1:0]       res_ready,
  output logic [NREQ*W_SUM-1:0] res_data,
  output logic [NREQ-1:0]       res_truncated,
  output logic                  seq_error
);
  localparam int IDW = $clog2(NREQ);
  localparam int FW  = $clog2(ADD_LATENCY + 1);

  typedef enum logic {S_FLUSH, S_RUN} state_t;

  state_t            state, state_nx;
  logic [FW-1:0]     flush_cnt;
  logic              run;
  logic [IDW-1:0]    rr_ptr, gnt_id;
  logic              gnt_vld;
  logic [NREQ-1:0]   has_credit, wr_en;
  logic [ADD_LATENCY:0] vld_pipe;
  logic [IDW-1:0]    id_pipe [ADD_LATENCY+1];
  logic              tag_out;

  // State register: FLUSH lasts ADD_LATENCY cycles after reset to soak up
  // stale results still inside the (unreset) adder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FLUSH;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Next state: leave FLUSH on its last counted cycle.
  always_comb begin
    state_nx = state;
    if (state == S_FLUSH && flush_cnt == FW'(ADD_LATENCY - 1)) state_nx = S_RUN;
  end

  // Outputs: round-robin grant from rr_ptr among requesters holding credit.
  always_comb begin
    int idx;
    idx       = 0;
    run       = (state == S_RUN);
    gnt_vld   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    if (run) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!gnt_vld && req_valid[idx] && has_credit[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  // Issue register toward the adder, and pointer advance past the winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_start <= 1'b0;
      add_in1   <= '0;
      add_in2   <= '0;
      rr_ptr    <= '0;
    end else begin
      add_start <= gnt_vld;
      if (gnt_vld) begin
        add_in1 <= req_in1[int'(gnt_id)*W_IN +: W_IN];
        add_in2 <= req_in2[int'(gnt_id)*W_IN +: W_IN];
        rr_ptr  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  // Tag line: stage 0 aligns with add_start, stage ADD_LATENCY with add_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int s = 0; s <= ADD_LATENCY; s++) id_pipe[s] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ADD_LATENCY-1:0], gnt_vld};
      id_pipe[0] <= gnt_id;
      for (int s = 1; s <= ADD_LATENCY; s++) id_pipe[s] <= id_pipe[s-1];
    end
  end

  assign tag_out = vld_pipe[ADD_LATENCY];

  // Steer a matched sum into its requester's FIFO.
  always_comb begin
    wr_en = '0;
    if (run && tag_out && add_done) wr_en[id_pipe[ADD_LATENCY]] = 1'b1;
  end

  // Sticky protocol error when add_done and the tag line disagree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seq_error <= 1'b0;
    else if (run && (tag_out != add_done)) seq_error <= 1'b1;
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    posit_add_sched_es3_lane #(.W(W_SUM), .DEPTH(RES_DEPTH)) u_lane (
      .clk           (clk),
      .reset_n       (reset_n),
      .grant         (req_valid[i] & req_ready[i]),
      .wr_en         (wr_en[i]),
      .wr_data       ({add_truncated, add_result}),
      .pop           (res_ready[i]),
      .has_credit    (has_credit[i]),
      .res_valid     (res_valid[i]),
      .res_data      (res_data[i*W_SUM +: W_SUM]),
      .res_truncated (res_truncated[i])
    );
  end
endmodule

// File: tb/tb_posit_add_sched_es3.sv
// Bench for posit_add_sched_es3: a stand-in adder pipeline, and a queue-based
// model (credit = entries queued per requester) predicting grants, issue and
// result delivery every cycle.
module tb_posit_add_sched_es3;
  localparam int NREQ = 4, L = 8, DEPTH = 4, W_IN = 38, W_SUM = 40;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid, req_ready, res_valid, res_ready, res_truncated;
  logic [NREQ*W_IN-1:0]  req_in1, req_in2;
  logic                  add_start, add_done, add_truncated, seq_error;
  logic [W_IN-1:0]       add_in1, add_in2;
  logic [W_SUM-1:0]      add_result;
  logic [NREQ*W_SUM-1:0] res_data;
  logic                  force_done;

  always #5 clk = ~clk;

  posit_add_sched_es3 #(.NREQ(NREQ), .ADD_LATENCY(L), .RES_DEPTH(DEPTH),
                        .W_IN(W_IN), .W_SUM(W_SUM)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .add_start(add_start),
    .add_in1(add_in1), .add_in2(add_in2), .add_result(add_result),
    .add_done(add_done), .add_truncated(add_truncated), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_truncated(res_truncated),
    .seq_error(seq_error)
  );

  // Serialized operand: {sgn, scale[8:0], frac[25:0], inf, zero}.
  // Serialized sum:     {sgn, scale[9:0], frac[26:0], inf, zero}.
  // Simplified same-sign adder (stimulus is positive, finite); returns {trunc, sum}.
  function automatic logic [W_SUM:0] ref_add(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
    logic [W_IN-1:0] big, sml;
    int sb, ss, d;
    logic [26:0] mb, ms, one, lostm;
    logic [27:0] s;
    logic trunc;
    if (a[0] && b[0]) return {1'b0, {W_SUM-1{1'b0}}, 1'b1};
    if (a[0] || b[0]) begin
      big = a[0] ? b : a;
      return {1'b0, big[37], 10'($signed(big[36:28])), big[27:2], 1'b0, big[1], 1'b0};
    end
    if ($signed(a[36:28]) >= $signed(b[36:28])) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    sb = $signed(big[36:28]);
    ss = $signed(sml[36:28]);
    d  = sb - ss;
    mb = {1'b1, big[27:2]};
    ms = {1'b1, sml[27:2]};
    one = 27'd1;
    if (d >= 27) begin trunc = 1'b1; ms = '0; end
    else begin
      lostm = (one << d) - one;
      trunc = ((ms & lostm) != '0);
      ms    = ms >> d;
    end
    s = {1'b0, mb} + {1'b0, ms};
    if (s[27]) return {trunc, big[37], 10'(sb + 1), s[26:0], 2'b00};
    return {trunc, big[37], 10'(sb), s[25:0], 1'b0, 2'b00};
  endfunction

  // Stand-in adder: fixed L-cycle pipeline, deliberately never reset.
  logic [L-1:0] ad_v = '0;
  logic [W_SUM:0] ad_d [L];
  always @(posedge clk) begin
    for (int k = L-1; k > 0; k--) begin
      ad_v[k] <= ad_v[k-1];
      ad_d[k] <= ad_d[k-1];
    end
    ad_v[0] <= add_start;
    ad_d[0] <= ref_add(add_in1, add_in2);
  end
  assign add_done      = ad_v[L-1] | force_done;
  assign add_result    = ad_d[L-1][W_SUM-1:0];
  assign add_truncated = ad_d[L-1][W_SUM];

  typedef struct { logic [W_SUM-1:0] sum; logic trunc; int due; } exp_t;
  exp_t exp_q [NREQ][$];

  int checks = 0, failures = 0;
  int cyc = 0, fl = 0, ptr = 0;
  logic exp_err = 1'b0, prev_hs = 1'b0;
  logic [W_IN-1:0] prev_a, prev_b;
  int gcnt [NREQ];
  logic [NREQ-1:0] obs_rdy, obs_rv;
  logic obs_err;
  logic [W_SUM-1:0] obs_rd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle of model prediction and comparison; inputs already applied.
  task automatic check_cycle();
    logic [NREQ-1:0] exp_rdy;
    logic ev;
    int g, idx;
    exp_t e;
    exp_rdy = '0;
    g = -1;
    obs_rdy = req_ready; obs_rv = res_valid; obs_err = seq_error;
    obs_rd0 = res_data[W_SUM-1:0];
    if (!reset_n) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_add_start", add_start, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_seq_error", seq_error, 0);
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
      ptr = 0; fl = 0; exp_err = 1'b0; prev_hs = 1'b0;
    end else begin
      if (fl >= L)
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr + k) % NREQ;
          if (g < 0 && req_valid[idx] && exp_q[idx].size() < DEPTH) g = idx;
        end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("add_start", add_start, prev_hs);
      if (prev_hs) begin
        chk("add_in1", add_in1, prev_a);
        chk("add_in2", add_in2, prev_b);
      end
      chk("seq_error", seq_error, exp_err);
      for (int i = 0; i < NREQ; i++) begin
        ev = (exp_q[i].size() > 0) && (exp_q[i][0].due <= cyc);
        chk($sformatf("res_valid%0d", i), res_valid[i], ev);
        if (ev) begin
          chk($sformatf("res_data%0d", i), res_data[i*W_SUM +: W_SUM], exp_q[i][0].sum);
          chk($sformatf("res_trunc%0d", i), res_truncated[i], exp_q[i][0].trunc);
          if (res_ready[i]) void'(exp_q[i].pop_front());
        end
        if (req_valid[i] && req_ready[i]) gcnt[i]++;
      end
      if (force_done && fl >= L) exp_err = 1'b1;
      if (g >= 0) begin
        prev_a = req_in1[g*W_IN +: W_IN];
        prev_b = req_in2[g*W_IN +: W_IN];
        {e.trunc, e.sum} = ref_add(prev_a, prev_b);
        e.due = cyc + L + 2;
        exp_q[g].push_back(e);
        ptr = (g + 1) % NREQ;
        prev_hs = 1'b1;
      end else prev_hs = 1'b0;
      fl++;
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic rand_ops();
    logic [W_IN-1:0] op;
    int sc;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 2; j++) begin
        sc = int'($urandom_range(20)) - 10;
        op = {1'b0, 9'(sc), 26'($urandom), 2'b00};
        if ($urandom_range(15) == 0) op = {{W_IN-1{1'b0}}, 1'b1};
        if (j == 0) req_in1[i*W_IN +: W_IN] = op;
        else        req_in2[i*W_IN +: W_IN] = op;
      end
  endtask

  localparam logic [W_IN-1:0]  ONE = '0;
  localparam logic [W_SUM-1:0] TWO = {1'b0, 10'd1, 27'd0, 2'b00};

  initial begin
    int n;
    logic seen;
    reset_n = 1'b1; req_valid = '0; res_ready = '0; force_done = 1'b0;
    req_in1 = '0; req_in2 = '0;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    step(); step();

    // Single op: 1.0 + 1.0 from requester 0
    reset_n = 1'b1;
    for (int k = 0; k < L + 2; k++) step();
    req_in1[0 +: W_IN] = ONE; req_in2[0 +: W_IN] = ONE; req_valid = 4'b0001;
    step();
    chk("single_grant", obs_rdy, 4'b0001);
    req_valid = '0;
    n = 0;
    do begin step(); n++; end while (!obs_rv[0] && n < 20);
    chk("single_latency", n, L + 2);
    chk("single_sum", obs_rd0, TWO);
    res_ready = 4'b0001; step(); res_ready = '0; step();
    chk("single_popped", obs_rv[0], 0);

    // Flush: all valid from reset release
    reset_n = 1'b0; step(); step();
    rand_ops(); req_valid = '1; res_ready = '1; reset_n = 1'b1;
    n = 0;
    forever begin step(); if (obs_rdy != 0 || n >= 20) break; n++; end
    chk("flush_first_cycle", n, L);
    chk("flush_first_gnt", obs_rdy, 4'b0001);
    chk("flush_seq_error", obs_err, 0);

    // Round robin, all valid, always popping
    for (int k = 0; k < 40; k++) begin rand_ops(); step(); end

    // Credit stall on requester 2
    req_valid = '0;
    for (int k = 0; k < 15; k++) step();
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    req_valid = '1; res_ready = 4'b1011;
    for (int k = 0; k < 40; k++) begin rand_ops(); step(); end
    chk("stall_gnt2", gcnt[2], DEPTH);
    chk("stall_others_run", gcnt[0] > 10, 1);
    gcnt[2] = 0;
    res_ready = 4'b1111; step(); res_ready = 4'b1011;
    for (int k = 0; k < 20; k++) begin rand_ops(); step(); end
    chk("stall_one_more", gcnt[2], 1);

    // Protocol error: done with no tag
    req_valid = '0; res_ready = '1;
    for (int k = 0; k < 20; k++) step();
    force_done = 1'b1; step(); force_done = 1'b0;
    step();
    chk("seq_error_set", obs_err, 1);
    for (int k = 0; k < 5; k++) step();
    chk("seq_error_sticky", obs_err, 1);

    // Reset with ops in flight
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin rand_ops(); step(); end
    reset_n = 1'b0; step(); step();
    reset_n = 1'b1; req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin step(); seen |= (obs_rv != 0); end
    chk("post_rst_no_results", seen, 0);
    chk("post_rst_seq_error", obs_err, 0);

    // Mixed random traffic, then drain
    for (int k = 0; k < 150; k++) begin
      rand_ops(); req_valid = NREQ'($urandom); res_ready = NREQ'($urandom); step();
    end
    req_valid = '0; res_ready = '1;
    for (int k = 0; k < 20; k++) step();
    chk("final_empty", obs_rv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/posit_add_sched_es3.md
Name: posit_add_sched_es3

Overview:
- Shares one fixed-latency es3 raw posit adder pipeline (38-bit serialized operands, start/done, no backpressure) among NREQ requesters.
- Arbitrates round-robin and issues at most one add per cycle.
- Tags each in-flight operation with its requester ID using a delay line matched to the adder latency.
- Steers each sum into a per-requester result FIFO. Credit counters guarantee no FIFO can overflow.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_LATENCY, 8, cycles from add_start high to the matching add_done high.
- RES_DEPTH, 4, entries per requester result FIFO (power of two); also the per-requester credit limit.
- W_IN, POSIT_SERIALIZED_WIDTH_ES3, serialized operand width (from posit_defines_es3).
- W_SUM, POSIT_SERIALIZED_WIDTH_SUM_ES3, serialized sum width.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  operation request per requester
- req_ready  out  NREQ  grant; one-hot or zero; combinational
- req_in1  in  NREQ*W_IN  operand A, requester i at [i*W_IN +: W_IN]
- req_in2  in  NREQ*W_IN  operand B, same packing
- add_start  out  1  to adder start, registered
- add_in1  out  W_IN  to adder in1, registered
- add_in2  out  W_IN  to adder in2, registered
- add_result  in  W_SUM  from adder result
- add_done  in  1  from adder done
- add_truncated  in  1  from adder truncated
- res_valid  out  NREQ  result FIFO non-empty
- res_ready  in  NREQ  result pop
- res_data  out  NREQ*W_SUM  FIFO head, requester i at [i*W_SUM +: W_SUM]
- res_truncated  out  NREQ  truncated flag stored with the head entry
- seq_error  out  1  sticky: add_done did not match the tag line

Behaviour:
Reset (async assert, sync release): the following clear to 0:
- add_start, add_in1, add_in2
- res_valid, seq_error
- RR pointer (resets to 0)
- credit counters
- FIFO pointers
- tag valids

After reset release, a flush counter runs ADD_LATENCY cycles (FLUSH state), then goes to RUN. In FLUSH:
- req_ready = 0.
- add_done is ignored (no write, no error). This discards stale ops still inside the unreset adder.

Credits:
- credit[i] = in-flight ops of i + FIFO occupancy of i; range 0..RES_DEPTH.
- +1 on grant to i; -1 on res_valid[i]&res_ready[i]; both in the same cycle leaves it unchanged.

Arbitration (RUN only):
- eligible[i] = req_valid[i] & (credit[i] < RES_DEPTH).
- Grant the first eligible index at or after the RR pointer, wrapping modulo NREQ.
- req_ready[g] = 1 for that cycle only. A handshake occurs when req_valid & req_ready are both high.
- On a grant, the pointer becomes g+1 mod NREQ. With no grant, the pointer holds.

Issue:
- On a handshake in cycle t: add_start=1 and add_in1/add_in2 = the granted operands in cycle t+1. Otherwise add_start=0 (never X; the adder treats X as idle).

Tag line:
- ADD_LATENCY-stage shift register of {valid, id}, loaded alongside add_start. The output stage aligns with add_done for the same op.
- Output valid & add_done: write {add_result, add_truncated} into FIFO[id] in that cycle.
- Any mismatch (done without a tag, or a tag without done): set seq_error (sticky until reset) and perform no write.

FIFOs:
- Registered; a write is visible on res_valid the next cycle. No bypass.
- Simultaneous push and pop are allowed.
- Overflow is impossible by credit construction.
- Pop on an empty FIFO is ignored.
- Pointers wrap modulo RES_DEPTH.

End-to-end latency: handshake cycle t -> add_start t+1 -> add_done t+1+ADD_LATENCY -> res_valid t+2+ADD_LATENCY (10 with defaults).

Throughput: one issue per cycle. Per-requester ordering is preserved. Results from different requesters are independent.

Reset mid-operation: all state clears immediately; no in-flight results are delivered; FLUSH then absorbs stale adder output.

Test Plan:
- Single op: req 0 sends in1=in2 = {sgn0, scale 0, frac 0, inf0, zero0} (1.0) at cycle t -> add_start at t+1; res_valid[0] at t+10; res_data[0] = sgn0, scale 1, frac 0 (2.0); credit[0] returns to 0 after pop.
- Flush: req_valid=4'b1111 held from reset release -> req_ready=0 for 8 cycles; first grant to req 0 on cycle 8; seq_error stays 0.
- Round robin: all four valid continuously, res_ready=1 -> grants 0,1,2,3,0,… one per cycle; each res_data[i] equals the sum of operands issued by i; no cross-routing.
- Credit stall: res_ready[2]=0, req 2 valid continuously -> exactly 4 grants to req 2, then req_ready[2]=0 while 0/1/3 continue. Raise res_ready[2] for one cycle -> exactly one further grant to req 2 after the pop.
- Protocol error: force add_done=1 in a cycle with no tag -> seq_error=1 next cycle and stays 1; no res_valid change.
- Reset mid-operation: assert reset_n=0 with 3 ops in flight -> res_valid=0 and add_start=0 immediately. After release, no results appear and seq_error stays 0 through FLUSH.
